slurm32_cpu_mem_arbiter: RTL and testbench

//  Shares the single 32-bit word-addressed memory port between the pipeline's instruction-fetch

---
 rtl/slurm32_cpu_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_slurm32_cpu_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm32_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : slurm32_cpu_mem_arbiter
//  Description : Shares one 32-bit word-addressed memory port between the
//                instruction-fetch requester and the load/store requester.
//                Only one bus transaction is outstanding at a time. Data
//                accesses win arbitration; a starvation counter forces a
//                fetch grant after STARVE_LIMIT consecutive data grants made
//                while a fetch was waiting.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_instruction_request/_address fetch request (level) and word address
//   o_instruction_valid/_in/_address_in  one-cycle fetch completion
//   i_fetch_flush                 PC reload; discard in-flight fetch result
//   i_load_memory/i_store_memory  data read / write request (level)
//   i_load_store_address          data word address
//   i_memory_out/i_memory_mask    store data and byte-lane mask
//   o_memory_in                   load data, valid with successful
//   o_memory_request_successful   low while a data request is unfinished
//   o_mem_*/i_mem_*               memory bus (valid/ready request phase,
//                                 rvalid/rdata response phase)
// ============================================================================
module slurm32_cpu_mem_arbiter #(
  parameter int ADDR_BITS    = 30,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // Instruction fetch side
  input  logic                 i_instruction_request,
  input  logic [ADDR_BITS-1:0] i_instruction_address,
  output logic                 o_instruction_valid,
  output logic [31:0]          o_instruction_in,
  output logic [ADDR_BITS-1:0] o_instruction_address_in,
  input  logic                 i_fetch_flush,
  // Load/store side
  input  logic                 i_load_memory,
  input  logic                 i_store_memory,
  input  logic [ADDR_BITS-1:0] i_load_store_address,
  input  logic [31:0]          i_memory_out,
  input  logic [3:0]           i_memory_mask,
  output logic [31:0]          o_memory_in,
  output logic                 o_memory_request_successful,
  // Memory bus
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic                 o_mem_wr,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  output logic [3:0]           o_mem_mask,
  input  logic                 i_mem_rvalid,
  input  logic [31:0]          i_mem_rdata
);

  localparam int                  c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_REQ  = 3'd1,
    S_F_WAIT = 3'd2,
    S_D_REQ  = 3'd3,
    S_D_WAIT = 3'd4
  } state_t;

  state_t                 r_state;
  logic [c_STARVE_W-1:0]  r_starve_cnt;
  logic                   r_flush;
  logic                   r_mem_valid;
  logic                   r_wr;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_mask;

  logic                   w_data_req;
  logic                   w_starved;
  logic                   w_grant_fetch;
  logic                   w_grant_data;
  logic                   w_fetch_done;
  logic                   w_data_done;

  // --------------------------------------------------------------------------
  // Arbitration (only evaluated in IDLE)
  // --------------------------------------------------------------------------
  assign w_data_req    = i_load_memory | i_store_memory;
  assign w_starved     = (r_starve_cnt == c_STARVE_MAX);
  assign w_grant_fetch = (r_state == S_IDLE) & i_instruction_request &
                         (~w_data_req | w_starved);
  assign w_grant_data  = (r_state == S_IDLE) & w_data_req & ~w_grant_fetch;

  assign w_fetch_done  = (r_state == S_F_WAIT) & i_mem_rvalid;
  assign w_data_done   = (r_state == S_D_WAIT) & i_mem_rvalid;

  // --------------------------------------------------------------------------
  // FSM, request capture, starvation counter and flush latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_flush      <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= 4'h0;
    end else begin
      // Starvation only matters while a fetch is actually waiting.
      if (!i_instruction_request || w_grant_fetch) begin
        r_starve_cnt <= '0;
      end else if (w_grant_data && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
      end

      // A flush seen anywhere between fetch grant and completion poisons
      // the result; the bus transaction itself is never aborted.
      if (w_grant_fetch) begin
        r_flush <= i_fetch_flush;
      end else if ((r_state == S_F_REQ || r_state == S_F_WAIT) && i_fetch_flush) begin
        r_flush <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_grant_fetch) begin
            r_state     <= S_F_REQ;
            r_mem_valid <= 1'b1;
            r_wr        <= 1'b0;
            r_addr      <= i_instruction_address;
            r_wdata     <= 32'h0;
            r_mask      <= 4'hF;
          end else if (w_grant_data) begin
            r_state     <= S_D_REQ;
            r_mem_valid <= 1'b1;
            r_wr        <= i_store_memory;
            r_addr      <= i_load_store_address;
            r_wdata     <= i_store_memory ? i_memory_out  : 32'h0;
            r_mask      <= i_store_memory ? i_memory_mask : 4'hF;
          end
        end
        S_F_REQ: begin
          if (i_mem_ready) begin
            r_state     <= S_F_WAIT;
            r_mem_valid <= 1'b0;
          end
        end
        S_D_REQ: begin
          if (i_mem_ready) begin
            r_state     <= S_D_WAIT;
            r_mem_valid <= 1'b0;
          end
        end
        S_F_WAIT, S_D_WAIT: begin
          // Return to IDLE; the next grant is decided one cycle later.
          if (i_mem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_mem_valid = r_mem_valid;
  assign o_mem_wr    = r_wr;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_mask  = r_mask;

  // Fetch completion is same-cycle so the requester can drop its level
  // request before the next IDLE arbitration.
  assign o_instruction_valid      = w_fetch_done & ~r_flush & ~i_fetch_flush;
  assign o_instruction_in         = o_instruction_valid ? i_mem_rdata : 32'h0;
  assign o_instruction_address_in = o_instruction_valid ? r_addr : '0;

  assign o_memory_request_successful = ~w_data_req | w_data_done;
  assign o_memory_in                 = (w_data_done & ~r_wr) ? i_mem_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_slurm32_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slurm32_cpu_mem_arbiter
//  Description : Directed testbench for slurm32_cpu_mem_arbiter with a
//                transaction-level reference model and a simple bus responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slurm32_cpu_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instruction_request;
  logic [29:0] instruction_address;
  logic        instruction_valid;
  logic [31:0] instruction_in;
  logic [29:0] instruction_address_in;
  logic        fetch_flush;
  logic        load_memory;
  logic        store_memory;
  logic [29:0] load_store_address;
  logic [31:0] memory_out;
  logic [3:0]  memory_mask;
  logic [31:0] memory_in;
  logic        memory_request_successful;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wr;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  slurm32_cpu_mem_arbiter #(.ADDR_BITS(30), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .i_instruction_request      (instruction_request),
    .i_instruction_address      (instruction_address),
    .o_instruction_valid        (instruction_valid),
    .o_instruction_in           (instruction_in),
    .o_instruction_address_in   (instruction_address_in),
    .i_fetch_flush              (fetch_flush),
    .i_load_memory              (load_memory),
    .i_store_memory             (store_memory),
    .i_load_store_address       (load_store_address),
    .i_memory_out               (memory_out),
    .i_memory_mask              (memory_mask),
    .o_memory_in                (memory_in),
    .o_memory_request_successful(memory_request_successful),
    .o_mem_valid                (mem_valid),
    .i_mem_ready                (mem_ready),
    .o_mem_wr                   (mem_wr),
    .o_mem_addr                 (mem_addr),
    .o_mem_wdata                (mem_wdata),
    .o_mem_mask                 (mem_mask),
    .i_mem_rvalid               (mem_rvalid),
    .i_mem_rdata                (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data the memory returns for a given word address.
  function automatic logic [31:0] rdata_for(input logic [29:0] a);
    return 32'h3000_0003 | ({2'b00, a} << 12);
  endfunction

  // --------------------------------------------------------------------------
  // Bus responder: mem_ready after ready_delay cycles of mem_valid,
  // mem_rvalid rsp_gap cycles after the cycle following acceptance.
  // --------------------------------------------------------------------------
  int          ready_delay = 0;
  int          rsp_gap     = 0;
  int          b_wait      = 0;
  int          b_cnt       = 0;
  bit          b_pend      = 0;
  bit          prev_valid  = 0;
  bit          prev_ready  = 0;
  logic [29:0] prev_addr   = '0;
  logic [29:0] b_addr      = '0;

  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_valid && prev_ready) begin
        b_pend = 1;
        b_cnt  = rsp_gap;
        b_addr = prev_addr;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (b_pend) begin
        if (b_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata_for(b_addr);
          b_pend     = 0;
        end else begin
          b_cnt--;
        end
      end
      if (mem_valid) begin
        if (b_wait < ready_delay) begin
          mem_ready = 1'b0;
          b_wait++;
        end else begin
          mem_ready = 1'b1;
          b_wait    = 0;
        end
      end else begin
        mem_ready = 1'b0;
        b_wait    = 0;
      end
      prev_valid = mem_valid;
      prev_ready = mem_ready;
      prev_addr  = mem_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: one outstanding transaction record plus a count of
  // consecutive data grants made while a fetch waited.
  // --------------------------------------------------------------------------
  bit          m_busy  = 0;  // a transaction has been granted and not finished
  bit          m_acc   = 0;  // bus has accepted the request
  bit          m_fetch = 0;
  bit          m_disc  = 0;  // fetch result must be thrown away
  bit          m_wr    = 0;
  logic [29:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_mask  = '0;
  int          m_starve = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy   = 0;
        m_acc    = 0;
        m_disc   = 0;
        m_starve = 0;
      end else begin
        if (m_busy && m_fetch && fetch_flush) m_disc = 1;
        if (!m_busy) begin
          if (instruction_request && (!(load_memory || store_memory) || m_starve == STARVE_LIMIT)) begin
            m_busy = 1; m_acc = 0; m_fetch = 1; m_wr = 0;
            m_addr = instruction_address; m_wdata = 32'h0; m_mask = 4'hF;
            m_disc = fetch_flush;
            m_starve = 0;
          end else if (load_memory || store_memory) begin
            m_busy = 1; m_acc = 0; m_fetch = 0; m_wr = store_memory;
            m_addr  = load_store_address;
            m_wdata = store_memory ? memory_out : 32'h0;
            m_mask  = store_memory ? memory_mask : 4'hF;
            if (instruction_request && m_starve < STARVE_LIMIT) m_starve++;
          end
        end else if (!m_acc) begin
          if (mem_ready) m_acc = 1;
        end else if (mem_rvalid) begin
          m_busy = 0;
        end
        if (!instruction_request) m_starve = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model, plus observation records
  // --------------------------------------------------------------------------
  bit          last_ivalid = 0, last_dsucc = 0, last_rvalid = 0;
  int          n_ivalid = 0, n_valid_cycles = 0, n_rvalid = 0;
  logic [31:0] cap_iin = '0, cap_min = '0, cap_wdata = '0;
  logic [29:0] cap_iaddr = '0;
  logic [3:0]  cap_mask = '0;
  logic        cap_wr = 1'b0;
  logic [29:0] acc_log[$];

  always @(negedge clk) begin
    bit          comp, exp_iv, exp_req;
    logic [31:0] exp_min;
    comp    = m_busy && m_acc && mem_rvalid;
    exp_iv  = comp && m_fetch && !m_disc && !fetch_flush;
    exp_req = m_busy && !m_acc;
    exp_min = (comp && !m_fetch && !m_wr) ? mem_rdata : 32'h0;
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, exp_req});
    if (exp_req) begin
      chk("mem_addr",  {2'b0, mem_addr}, {2'b0, m_addr});
      chk("mem_wr",    {31'b0, mem_wr},  {31'b0, m_wr});
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_mask",  {28'b0, mem_mask}, {28'b0, m_mask});
    end
    chk("instruction_valid", {31'b0, instruction_valid}, {31'b0, exp_iv});
    chk("instruction_in", instruction_in, exp_iv ? mem_rdata : 32'h0);
    chk("instruction_address_in", {2'b0, instruction_address_in}, exp_iv ? {2'b0, m_addr} : 32'h0);
    chk("memory_request_successful", {31'b0, memory_request_successful},
        {31'b0, (!(load_memory || store_memory)) || (comp && !m_fetch)});
    chk("memory_in", memory_in, exp_min);

    last_ivalid = instruction_valid;
    last_dsucc  = (load_memory || store_memory) && memory_request_successful;
    last_rvalid = mem_rvalid;
    if (instruction_valid) begin
      n_ivalid++;
      cap_iin   = instruction_in;
      cap_iaddr = instruction_address_in;
    end
    if (last_dsucc) cap_min = memory_in;
    if (mem_rvalid) n_rvalid++;
    if (mem_valid) n_valid_cycles++;
    if (mem_valid && mem_ready) begin
      acc_log.push_back(mem_addr);
      cap_wr    = mem_wr;
      cap_wdata = mem_wdata;
      cap_mask  = mem_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = instruction_valid, 1 = data success, 2 = mem_rvalid
  task automatic wait_for(input int kind, input string name, output int steps);
    bit hit;
    hit   = 0;
    steps = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      steps++;
      hit = (kind == 0) ? last_ivalid : (kind == 1) ? last_dsucc : last_rvalid;
      if (hit) break;
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, event never seen", name, steps);
    end
  endtask

  logic [29:0] exp3[6];
  int          st;

  initial begin
    rst = 1'b1;
    instruction_request = 0; instruction_address = '0; fetch_flush = 0;
    load_memory = 0; store_memory = 0; load_store_address = '0;
    memory_out = '0; memory_mask = '0;
    repeat (3) step();
    @(negedge clk);
    chk("reset mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("reset mem_addr",  {2'b0, mem_addr}, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset mem_mask",  {28'b0, mem_mask}, 32'h0);
    chk("reset mem_wr",    {31'b0, mem_wr}, 32'h0);
    chk("reset successful", {31'b0, memory_request_successful}, 32'h1);
    step();
    rst = 1'b0;
    step();

    // 1: fetch only, zero-wait bus
    n_ivalid = 0;
    instruction_request = 1; instruction_address = 30'h10;
    wait_for(0, "t1 fetch", st);
    instruction_request = 0;
    chk("t1 latency", st, 3);
    chk("t1 instruction_in", cap_iin, 32'h3001_0003);
    chk("t1 address_in", {2'b0, cap_iaddr}, 32'h10);
    chk("t1 pulses", n_ivalid, 1);
    repeat (2) step();

    // 2: load and fetch together, load goes first
    acc_log.delete();
    load_memory = 1; load_store_address = 30'h40;
    instruction_request = 1; instruction_address = 30'h44;
    wait_for(1, "t2 load", st);
    load_memory = 0;
    chk("t2 memory_in", cap_min, 32'h3004_0003);
    wait_for(0, "t2 fetch", st);
    instruction_request = 0;
    chk("t2 grants", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("t2 first grant", {2'b0, acc_log[0]}, 32'h40);
      chk("t2 second grant", {2'b0, acc_log[1]}, 32'h44);
    end
    repeat (2) step();

    // 3: starvation limit with load held continuously
    acc_log.delete();
    rsp_gap = 1;
    exp3 = '{30'h80, 30'h80, 30'h80, 30'h80, 30'h90, 30'h80};
    load_memory = 1; load_store_address = 30'h80;
    instruction_request = 1; instruction_address = 30'h90;
    wait_for(0, "t3 fetch", st);
    instruction_request = 0;
    wait_for(1, "t3 data", st);
    load_memory = 0;
    chk("t3 grants", acc_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_log.size()) chk($sformatf("t3 grant %0d", i), {2'b0, acc_log[i]}, {2'b0, exp3[i]});
    end
    repeat (2) step();

    // 4: store with mem_ready held low three cycles
    acc_log.delete();
    rsp_gap = 0; ready_delay = 3; n_valid_cycles = 0;
    store_memory = 1; load_store_address = 30'h20;
    memory_out = 32'hDEAD_BEEF; memory_mask = 4'b0011;
    wait_for(1, "t4 store", st);
    store_memory = 0;
    chk("t4 valid cycles", n_valid_cycles, 4);
    chk("t4 mem_wr", {31'b0, cap_wr}, 32'h1);
    chk("t4 mem_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("t4 mem_mask", {28'b0, cap_mask}, 32'h3);
    chk("t4 mem_addr", acc_log.size() > 0 ? {2'b0, acc_log[0]} : 32'hFFFF_FFFF, 32'h20);
    repeat (2) step();

    // 5: flush while the fetch is in flight, then a normal fetch
    ready_delay = 0; rsp_gap = 2; n_ivalid = 0;
    instruction_request = 1; instruction_address = 30'h30;
    step(); step();
    fetch_flush = 1; instruction_address = 30'h34;
    step();
    fetch_flush = 0;
    wait_for(2, "t5 flushed response", st);
    chk("t5 flushed pulses", n_ivalid, 0);
    wait_for(0, "t5 refetch", st);
    instruction_request = 0;
    chk("t5 pulses", n_ivalid, 1);
    chk("t5 address_in", {2'b0, cap_iaddr}, 32'h34);
    chk("t5 instruction_in", cap_iin, 32'h3003_4003);
    repeat (2) step();

    // 6: reset while waiting for a load response that arrives late
    rsp_gap = 5;
    load_memory = 1; load_store_address = 30'h50;
    step(); step();
    rst = 1; load_memory = 0;
    step();
    rst = 0;
    n_ivalid = 0; n_rvalid = 0; n_valid_cycles = 0;
    repeat (8) step();
    chk("t6 late rvalid seen", n_rvalid, 1);
    chk("t6 pulses", n_ivalid, 0);
    chk("t6 bus idle", n_valid_cycles, 0);
    @(negedge clk);
    chk("t6 successful", {31'b0, memory_request_successful}, 32'h1);
    chk("t6 memory_in", memory_in, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
